// File: rtl/enigma_pkg.sv
// Shared definitions for the Enigma rotor sequencer.
// Holds the alphabet size, letter width, FSM state encoding, the historical
// rotor notch positions and small helpers for position arithmetic.
package enigma_pkg;

  localparam int ALPHA_SIZE = 26;
  localparam int LETTER_W   = 5;

  // Turnover notches of the classic rotors I, II and III (Q, E, V).
  localparam int NOTCH_I    = 16;
  localparam int NOTCH_II   = 4;
  localparam int NOTCH_III  = 21;

  typedef logic [LETTER_W-1:0] letter_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STEP = 2'd1,
    CORE = 2'd2,
    HOLD = 2'd3
  } state_t;

  localparam letter_t LAST_LETTER = letter_t'(ALPHA_SIZE - 1);

  // Advance a rotor position by one, wrapping Z back to A.
  function automatic letter_t wrap_inc(input letter_t pos);
    return (pos == LAST_LETTER) ? '0 : pos + letter_t'(1);
  endfunction

  // Out-of-alphabet start positions are forced to A.
  function automatic letter_t sanitize(input letter_t pos);
    return (pos > LAST_LETTER) ? '0 : pos;
  endfunction

endpackage

// File: rtl/enigma_rotor_sequencer_if.sv
// Letter stream interface of the rotor sequencer.
//   in_valid / in_ready / in_letter    : plaintext letter handshake
//   out_valid / out_ready / out_letter : ciphertext letter handshake
// Modport master is the environment (letter source and sink); modport slave
// is the sequencer.
interface enigma_rotor_sequencer_if;
  import enigma_pkg::*;

  logic    in_valid;
  logic    in_ready;
  letter_t in_letter;
  logic    out_valid;
  logic    out_ready;
  letter_t out_letter;

  modport master (
    output in_valid, in_letter, out_ready,
    input  in_ready, out_valid, out_letter
  );

  modport slave (
    input  in_valid, in_letter, out_ready,
    output in_ready, out_valid, out_letter
  );

endinterface

// File: rtl/enigma_rotor_stepper.sv
// Combinational rotor stepping: maps current (l, m, r) positions and the
// right/middle notch positions to the positions after one key press.
//   pos_l/m/r   : current rotor positions, 0..25
//   notch_r     : right rotor position that carries into the middle rotor
//   notch_m     : middle rotor position that carries into the left rotor
//   next_l/m/r  : stepped positions
// All decisions look at the pre-step positions. The middle rotor also moves
// when it sits on its own notch, which produces the Enigma double-step.
module enigma_rotor_stepper
  import enigma_pkg::*;
(
  input  letter_t pos_l,
  input  letter_t pos_m,
  input  letter_t pos_r,
  input  letter_t notch_r,
  input  letter_t notch_m,
  output letter_t next_l,
  output letter_t next_m,
  output letter_t next_r
);

  logic carry_r;
  logic carry_m;

  assign carry_r = (pos_r == notch_r);
  assign carry_m = (pos_m == notch_m);

  assign next_r = wrap_inc(pos_r);
  assign next_m = (carry_r || carry_m) ? wrap_inc(pos_m) : pos_m;
  assign next_l = carry_m ? wrap_inc(pos_l) : pos_l;

endmodule

// File: rtl/enigma_rotor_sequencer.sv
// Rotor sequencer around a combinational Enigma cipher core.
//   clk, rst           : clock and asynchronous active-low reset
//   cfg_load, cfg_pos_*: rotor start position load, honoured in IDLE only
//   bus (slave)        : plaintext in / ciphertext out handshakes
//   core_letter/pos_*  : letter and rotor positions driven to the core
//   core_result        : ciphertext returned combinationally by the core
//   err                : one-cycle pulse when an out-of-range letter is dropped
//   char_count         : number of letters enciphered (wrapping)
// One letter walks IDLE -> STEP -> CORE -> HOLD; the rotors step before the
// letter is presented to the core, as on the real machine.
module enigma_rotor_sequencer
  import enigma_pkg::*;
#(
  parameter int NOTCH_R = NOTCH_III,
  parameter int NOTCH_M = NOTCH_II,
  parameter int CNT_W   = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cfg_load,
  input  letter_t                    cfg_pos_l,
  input  letter_t                    cfg_pos_m,
  input  letter_t                    cfg_pos_r,
  enigma_rotor_sequencer_if.slave    bus,
  output letter_t                    core_letter,
  output letter_t                    core_pos_l,
  output letter_t                    core_pos_m,
  output letter_t                    core_pos_r,
  input  letter_t                    core_result,
  output logic                       err,
  output logic [CNT_W-1:0]           char_count
);

  state_t             state_reg, state_next;
  letter_t            pos_l_reg, pos_l_next;
  letter_t            pos_m_reg, pos_m_next;
  letter_t            pos_r_reg, pos_r_next;
  letter_t            letter_reg, letter_next;
  letter_t            out_letter_reg, out_letter_next;
  logic               err_reg, err_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;

  letter_t            step_l, step_m, step_r;

  enigma_rotor_stepper u_stepper (
    .pos_l   (pos_l_reg),
    .pos_m   (pos_m_reg),
    .pos_r   (pos_r_reg),
    .notch_r (letter_t'(NOTCH_R)),
    .notch_m (letter_t'(NOTCH_M)),
    .next_l  (step_l),
    .next_m  (step_m),
    .next_r  (step_r)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= IDLE;
      pos_l_reg      <= '0;
      pos_m_reg      <= '0;
      pos_r_reg      <= '0;
      letter_reg     <= '0;
      out_letter_reg <= '0;
      err_reg        <= 1'b0;
      cnt_reg        <= '0;
    end else begin
      state_reg      <= state_next;
      pos_l_reg      <= pos_l_next;
      pos_m_reg      <= pos_m_next;
      pos_r_reg      <= pos_r_next;
      letter_reg     <= letter_next;
      out_letter_reg <= out_letter_next;
      err_reg        <= err_next;
      cnt_reg        <= cnt_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    pos_l_next      = pos_l_reg;
    pos_m_next      = pos_m_reg;
    pos_r_next      = pos_r_reg;
    letter_next     = letter_reg;
    out_letter_next = out_letter_reg;
    err_next        = 1'b0;
    cnt_next        = cnt_reg;

    case (state_reg)
      IDLE: begin
        // Configuration takes priority; the letter is not consumed then.
        if (cfg_load) begin
          pos_l_next = sanitize(cfg_pos_l);
          pos_m_next = sanitize(cfg_pos_m);
          pos_r_next = sanitize(cfg_pos_r);
        end else if (bus.in_valid) begin
          if (bus.in_letter <= LAST_LETTER) begin
            letter_next = bus.in_letter;
            state_next  = STEP;
          end else begin
            // Invalid letters are swallowed so the source is never stuck.
            err_next = 1'b1;
          end
        end
      end
      STEP: begin
        pos_l_next = step_l;
        pos_m_next = step_m;
        pos_r_next = step_r;
        state_next = CORE;
      end
      CORE: begin
        out_letter_next = core_result;
        cnt_next        = cnt_reg + CNT_W'(1);
        state_next      = HOLD;
      end
      HOLD: begin
        if (bus.out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.in_ready   = (state_reg == IDLE) && !cfg_load;
  assign bus.out_valid  = (state_reg == HOLD);
  assign bus.out_letter = out_letter_reg;

  assign core_letter = letter_reg;
  assign core_pos_l  = pos_l_reg;
  assign core_pos_m  = pos_m_reg;
  assign core_pos_r  = pos_r_reg;

  assign err        = err_reg;
  assign char_count = cnt_reg;

endmodule

// File: tb/tb_enigma_rotor_sequencer.sv
module tb_enigma_rotor_sequencer;
  import enigma_pkg::*;

  logic        clk;
  logic        rst;
  logic        cfg_load;
  letter_t     cfg_pos_l, cfg_pos_m, cfg_pos_r;
  letter_t     core_letter, core_pos_l, core_pos_m, core_pos_r;
  letter_t     core_result;
  logic        err;
  logic [15:0] char_count;

  letter_t     st_l, st_m, st_r, st_nl, st_nm, st_nr;

  int total = 0;
  int bad   = 0;

  enigma_rotor_sequencer_if bus ();

  enigma_rotor_sequencer #(
    .NOTCH_R (21),
    .NOTCH_M (4),
    .CNT_W   (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_load    (cfg_load),
    .cfg_pos_l   (cfg_pos_l),
    .cfg_pos_m   (cfg_pos_m),
    .cfg_pos_r   (cfg_pos_r),
    .bus         (bus),
    .core_letter (core_letter),
    .core_pos_l  (core_pos_l),
    .core_pos_m  (core_pos_m),
    .core_pos_r  (core_pos_r),
    .core_result (core_result),
    .err         (err),
    .char_count  (char_count)
  );

  enigma_rotor_stepper u_step_tb (
    .pos_l   (st_l),
    .pos_m   (st_m),
    .pos_r   (st_r),
    .notch_r (5'd21),
    .notch_m (5'd4),
    .next_l  (st_nl),
    .next_m  (st_nm),
    .next_r  (st_nr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_pos(input string tag, input int l, input int m, input int r);
    chk({tag, "_l"}, 32'(core_pos_l), 32'(l));
    chk({tag, "_m"}, 32'(core_pos_m), 32'(m));
    chk({tag, "_r"}, 32'(core_pos_r), 32'(r));
  endtask

  task automatic cfg(input letter_t l, input letter_t m, input letter_t r);
    cfg_load  = 1'b1;
    cfg_pos_l = l;
    cfg_pos_m = m;
    cfg_pos_r = r;
    #1;
    chk("cfg_in_ready_low", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    cfg_load = 1'b0;
  endtask

  // Full letter transaction with out_ready high; called and returns at a negedge in IDLE.
  task automatic xact(input string tag, input letter_t letter, input letter_t res,
                      input int el, input int em, input int er);
    core_result   = res;
    bus.in_letter = letter;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    @(negedge clk);                       // STEP
    bus.in_valid = 1'b0;
    chk({tag, "_ov_step"}, 32'(bus.out_valid), 32'd0);
    @(negedge clk);                       // CORE
    chk_pos({tag, "_pos"}, el, em, er);
    chk({tag, "_core_letter"}, 32'(core_letter), 32'(letter));
    chk({tag, "_ov_core"}, 32'(bus.out_valid), 32'd0);
    @(negedge clk);                       // HOLD, third cycle after accept
    chk({tag, "_ov_hold"}, 32'(bus.out_valid), 32'd1);
    chk({tag, "_out_letter"}, 32'(bus.out_letter), 32'(res));
    @(negedge clk);                       // back in IDLE
    chk({tag, "_ov_done"}, 32'(bus.out_valid), 32'd0);
    $display("xact %s letter=%0d out=%0d pos=%0d/%0d/%0d count=%0d",
             tag, letter, bus.out_letter, core_pos_l, core_pos_m, core_pos_r, char_count);
  endtask

  initial begin
    rst = 1'b0; cfg_load = 1'b0;
    cfg_pos_l = '0; cfg_pos_m = '0; cfg_pos_r = '0;
    bus.in_valid = 1'b0; bus.in_letter = '0; bus.out_ready = 1'b1;
    core_result = 5'd9;
    st_l = '0; st_m = '0; st_r = '0;

    // Stepper standalone
    st_l = 0;  st_m = 3;  st_r = 21; #1;
    chk("stp_a_l", 32'(st_nl), 0); chk("stp_a_m", 32'(st_nm), 4); chk("stp_a_r", 32'(st_nr), 22);
    st_l = 1;  st_m = 4;  st_r = 10; #1;
    chk("stp_b_l", 32'(st_nl), 2); chk("stp_b_m", 32'(st_nm), 5); chk("stp_b_r", 32'(st_nr), 11);
    st_l = 25; st_m = 4;  st_r = 25; #1;
    chk("stp_c_l", 32'(st_nl), 0); chk("stp_c_m", 32'(st_nm), 5); chk("stp_c_r", 32'(st_nr), 0);
    st_l = 3;  st_m = 25; st_r = 21; #1;
    chk("stp_d_l", 32'(st_nl), 3); chk("stp_d_m", 32'(st_nm), 0); chk("stp_d_r", 32'(st_nr), 22);
    $display("stepper vectors done");

    // Reset state
    @(negedge clk); @(negedge clk);
    chk("rst_ov", 32'(bus.out_valid), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_cnt", 32'(char_count), 0);
    chk("rst_out_letter", 32'(bus.out_letter), 0);
    chk("rst_core_letter", 32'(core_letter), 0);
    chk_pos("rst_pos", 0, 0, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 1);

    // First letter from 0/0/0
    xact("t1", 5'd1, 5'd9, 0, 0, 1);
    chk("t1_cnt", 32'(char_count), 1);

    // Double-step sequence
    cfg(5'd0, 5'd3, 5'd21);
    chk_pos("t2_cfg", 0, 3, 21);
    xact("t2a", 5'd2, 5'd5, 0, 4, 22);
    xact("t2b", 5'd3, 5'd7, 1, 5, 23);
    chk("t2_cnt", 32'(char_count), 3);

    // Right rotor wrap without carry, then sanitized load
    cfg(5'd0, 5'd0, 5'd25);
    xact("t3", 5'd25, 5'd0, 0, 0, 0);
    cfg(5'd30, 5'd2, 5'd7);
    chk_pos("t3_cfg", 0, 2, 7);

    // Invalid letter dropped
    bus.in_valid = 1'b1; bus.in_letter = 5'd27;
    #1;
    chk("t4_in_ready", 32'(bus.in_ready), 1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("t4_err_hi", 32'(err), 1);
    chk("t4_ov", 32'(bus.out_valid), 0);
    chk_pos("t4_pos", 0, 2, 7);
    @(negedge clk);
    chk("t4_err_lo", 32'(err), 0);
    chk("t4_cnt", 32'(char_count), 4);
    $display("xact t4 letter=27 dropped err pulse");

    // Back-pressure in HOLD with ignored cfg_load
    bus.out_ready = 1'b0; core_result = 5'd11;
    bus.in_valid = 1'b1; bus.in_letter = 5'd4;
    @(negedge clk);  bus.in_valid = 1'b0;   // STEP
    @(negedge clk);                           // CORE
    @(negedge clk);                           // HOLD
    core_result = 5'd20;
    for (int i = 0; i < 5; i++) begin
      chk("t5_ov", 32'(bus.out_valid), 1);
      chk("t5_out_letter", 32'(bus.out_letter), 11);
      chk("t5_in_ready", 32'(bus.in_ready), 0);
      if (i == 2) begin
        cfg_load = 1'b1; cfg_pos_l = 10; cfg_pos_m = 10; cfg_pos_r = 10;
      end else begin
        cfg_load = 1'b0;
      end
      @(negedge clk);
    end
    chk_pos("t5_pos", 0, 2, 8);
    chk("t5_ov_still", 32'(bus.out_valid), 1);
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("t5_ov_done", 32'(bus.out_valid), 0);
    chk_pos("t5_pos_after", 0, 2, 8);
    chk("t5_cnt", 32'(char_count), 5);
    $display("xact t5 letter=4 out=11 held 5 cycles");

    // Reset during CORE
    cfg(5'd5, 5'd5, 5'd5);
    bus.in_valid = 1'b1; bus.in_letter = 5'd6; core_result = 5'd3;
    @(negedge clk);  bus.in_valid = 1'b0;   // STEP
    @(negedge clk);                           // CORE
    chk_pos("t6_core", 5, 5, 6);
    rst = 1'b0;
    #1;
    chk("t6_ov", 32'(bus.out_valid), 0);
    chk("t6_cnt", 32'(char_count), 0);
    chk_pos("t6_pos", 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    chk("t6_ov_later", 32'(bus.out_valid), 0);
    rst = 1'b1;
    @(negedge clk);
    $display("xact t6 reset during CORE");
    xact("t6b", 5'd8, 5'd14, 0, 0, 1);
    chk("t6_cnt_after", 32'(char_count), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/enigma_rotor_sequencer.md
Name: enigma_rotor_sequencer

Overview:
Sequences the combinational enigma_implementation_onward cipher core, one letter per transaction. Accepts plaintext letters over a valid/ready handshake and advances three rotor positions per letter, odometer style with double-step. Drives the core with the letter and the stepped positions, registers the ciphertext, and returns it over a valid/ready handshake. Also owns the initial-position configuration load.

Parameters:
NOTCH_R, 21, position of the right rotor at which it carries into the middle rotor.
NOTCH_M, 4, position of the middle rotor at which it carries into the left rotor and double-steps itself.
CNT_W, 16, width of the processed-letter counter.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-low reset.
cfg_load  in  1  load rotor start positions; honoured only in IDLE.
cfg_pos_l  in  5  left rotor start position.
cfg_pos_m  in  5  middle rotor start position.
cfg_pos_r  in  5  right rotor start position.
in_valid  in  1  plaintext letter valid.
in_ready  out  1  sequencer can accept a letter.
in_letter  in  5  plaintext letter, 0..25.
core_letter  out  5  letter driven to the cipher core.
core_pos_l  out  5  left rotor position driven to the core.
core_pos_m  out  5  middle rotor position driven to the core.
core_pos_r  out  5  right rotor position driven to the core.
core_result  in  5  combinational ciphertext returned by the core.
out_valid  out  1  ciphertext valid.
out_ready  in  1  downstream accepts the ciphertext.
out_letter  out  5  registered ciphertext.
err  out  1  one-cycle pulse when an invalid letter is dropped.
char_count  out  CNT_W  count of letters enciphered.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; all positions 0; core_letter 0; out_letter 0; out_valid 0; err 0; char_count 0. in_ready reads 1 after release.
- FSM states are IDLE, STEP, CORE and HOLD.
- IDLE:
  - in_ready = ~cfg_load.
  - cfg_load=1: register the three cfg positions; any value >25 loads as 0. Stay in IDLE.
  - in_valid=1 and cfg_load=0 with in_letter<=25: latch the letter, go to STEP.
  - in_valid=1 and cfg_load=0 with in_letter>25: consume the letter (in_ready=1), pulse err for one cycle, no stepping, no count. Stay in IDLE.
- STEP (one cycle): all step decisions use the pre-step positions.
  - The right rotor always advances.
  - The middle rotor advances if pos_r==NOTCH_R or pos_m==NOTCH_M (double-step).
  - The left rotor advances if pos_m==NOTCH_M.
  - Each position wraps 25 to 0.
  - Go to CORE.
- CORE (one cycle):
  - core_letter and core_pos_* are driven from registers, so the core settles within the cycle.
  - At the clock edge, out_letter <= core_result, char_count increments (wraps at 2^CNT_W), go to HOLD.
- HOLD:
  - out_valid=1 and out_letter is held stable.
  - out_valid&&out_ready returns the FSM to IDLE next cycle; out_valid deasserts.
- Latency: accept edge to out_valid high is 3 cycles. With out_ready held high, peak throughput is one letter per 4 cycles.
- in_ready=0 in STEP, CORE and HOLD. cfg_load is ignored outside IDLE and is not queued.
- core_pos_* always reflect the current rotor registers. core_letter holds its last value between transactions.
- Reset mid-transaction aborts it: the letter is lost and positions return to 0, not to the cfg values.

Decomposition:
- Package enigma_pkg holds:
  - ALPHA_SIZE=26, LETTER_W=5;
  - the state enum {IDLE, STEP, CORE, HOLD};
  - default notch constants NOTCH_I=16, NOTCH_II=4, NOTCH_III=21.
- Sub-module enigma_rotor_stepper: a combinational block mapping current (l,m,r) and the notches to next (l,m,r), including double-step and wrap. It is instantiated once and exercised standalone by the bench.

Test Plan:
- Reset, positions 0/0/0, send letter 1 with core_result tied to 9 -> core_pos = 0/0/1 in CORE; out_valid rises 3 cycles after accept with out_letter=9; char_count=1.
- cfg_load 0/3/21, send two letters -> positions 0/4/22 after the first, then 1/5/23 after the second (double-step).
- cfg_load 0/0/25, send one letter -> positions 0/0/0 (wrap with no carry); cfg_load 30/2/7 -> loads 0/2/7.
- Send in_letter=27 in IDLE -> err high for exactly 1 cycle, positions unchanged, char_count unchanged, out_valid stays 0.
- out_ready held low for 5 cycles in HOLD -> out_valid and out_letter stable throughout; in_ready=0; a cfg_load pulse during HOLD has no effect.
- Assert rst low during CORE after cfg 5/5/5 -> out_valid=0 immediately, positions 0/0/0, char_count 0; the next letter yields positions 0/0/1.
